// File: rtl/spart_tx.sv
// spart_tx: double-buffered UART transmitter, 8N1 at 4800..38400 baud from CLK_HZ.
// Optional macro SPART_TX_PARITY_EN inserts an even-parity bit between data and stop.
`timescale 1ns/1ps
`default_nettype none

module spart_tx #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tbr,
  output logic       busy,
  output logic       txd
);

  localparam logic [31:0] c_DIV_4800  = 32'(CLK_HZ / 4800);
  localparam logic [31:0] c_DIV_9600  = 32'(CLK_HZ / 9600);
  localparam logic [31:0] c_DIV_19200 = 32'(CLK_HZ / 19200);
  localparam logic [31:0] c_DIV_38400 = 32'(CLK_HZ / 38400);

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
  } state_t;
`endif

  function automatic logic [31:0] f_div(input logic [1:0] sel);
    logic [31:0] d;
    case (sel)
      2'b00:   d = c_DIV_4800;
      2'b01:   d = c_DIV_9600;
      2'b10:   d = c_DIV_19200;
      default: d = c_DIV_38400;
    endcase
    return d;
  endfunction

  state_t      r_state;
  logic [7:0]  r_hold;
  logic        r_tbr;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [31:0] r_baud_cnt;
  logic [31:0] r_div;
  logic        r_busy;
  logic        r_txd;
`ifdef SPART_TX_PARITY_EN
  logic        r_parity;
`endif

  logic w_accept;
  logic w_bit_end;
  logic w_load;

  assign w_accept  = tx_start & r_tbr;
  assign w_bit_end = (r_baud_cnt == (r_div - 32'd1));
  // Holding register drains into the shifter from IDLE, or seamlessly at the end of STOP.
  assign w_load    = !r_tbr && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hold     <= 8'h00;
      r_tbr      <= 1'b1;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_baud_cnt <= 32'd0;
      r_div      <= 32'd0;
      r_busy     <= 1'b0;
      r_txd      <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_hold <= tx_data;
        r_tbr  <= 1'b0;
      end

      if (r_state != IDLE) begin
        r_baud_cnt <= w_bit_end ? 32'd0 : r_baud_cnt + 32'd1;
      end

      case (r_state)
        IDLE: ;
        START: begin
          if (w_bit_end) begin
            r_state   <= DATA;
            r_bit_cnt <= 3'd0;
            r_txd     <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
              r_state <= PARITY;
              r_txd   <= r_parity;
`else
              r_state <= STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
        end
`ifdef SPART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_txd   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_txd   <= 1'b1;
        end
      endcase

      // Placed after the case so a back-to-back load overrides the STOP->IDLE exit.
      if (w_load) begin
        r_state    <= START;
        r_shift    <= r_hold;
        r_tbr      <= 1'b1;
        r_txd      <= 1'b0;
        r_div      <= f_div(br_cfg);
        r_baud_cnt <= 32'd0;
        r_busy     <= 1'b1;
`ifdef SPART_TX_PARITY_EN
        r_parity   <= ^r_hold;
`endif
      end
    end
  end

  assign tbr  = r_tbr;
  assign busy = r_busy;
  assign txd  = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_spart_tx.sv
// tb_spart_tx: randomized and directed frame checks of spart_tx against a per-cycle line model.
`timescale 1ns/1ps
`default_nettype none

module tb_spart_tx;

  localparam int TB_CLK_HZ = 192000;
`ifdef SPART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tbr;
  logic       busy;
  logic       txd;

  int n_cmp = 0;
  int n_err = 0;

  logic q_txd[$];
  logic q_busy[$];
  logic q_tbr[$];

  spart_tx #(.CLK_HZ(TB_CLK_HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tbr      (tbr),
    .busy     (busy),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  function automatic int div_of(input logic [1:0] c);
    int baud;
    case (c)
      2'd0:    baud = 4800;
      2'd1:    baud = 9600;
      2'd2:    baud = 19200;
      default: baud = 38400;
    endcase
    return TB_CLK_HZ / baud;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Line model: start bit, LSB-first data, optional even parity, stop bit; each bit d cycles.
  task automatic push_frame(input logic [7:0] b, input int d, input logic first_tbr, input logic rest_tbr);
    logic fb [NB];
    fb[0] = 1'b0;
    for (int k = 0; k < 8; k++) fb[k+1] = b[k];
`ifdef SPART_TX_PARITY_EN
    fb[9] = ^b;
`endif
    fb[NB-1] = 1'b1;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < d; c++) begin
        q_txd.push_back(fb[k]);
        q_busy.push_back(1'b1);
        q_tbr.push_back((k == 0 && c == 0) ? first_tbr : rest_tbr);
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) begin
      q_txd.push_back(1'b1);
      q_busy.push_back(1'b0);
      q_tbr.push_back(1'b1);
    end
  endtask

  task automatic step_check(input int idx);
    logic e_txd, e_busy, e_tbr;
    @(negedge clk);
    e_txd  = q_txd.pop_front();
    e_busy = q_busy.pop_front();
    e_tbr  = q_tbr.pop_front();
    chk($sformatf("txd@%0d", idx),  txd,  e_txd);
    chk($sformatf("busy@%0d", idx), busy, e_busy);
    chk($sformatf("tbr@%0d", idx),  tbr,  e_tbr);
  endtask

  // junk_at: -1 none, -2 on the transfer edge of frame 1, -3 random. cfg_at: -1 none, -3 random.
  task automatic do_test(input logic [1:0] cfg, input logic [7:0] b1, input logic pair,
                         input logic [7:0] b2, input logic hold2, input int junk_in,
                         input int cfg_in, input logic [1:0] new_cfg);
    int d1, d2, len1, junk_at, cfg_at, i;
    d1   = div_of(cfg);
    len1 = NB * d1;
    junk_at = junk_in;
    cfg_at  = cfg_in;
    if (junk_at == -2) junk_at = len1 - 1;
    if (junk_at == -3) junk_at = pair ? int'($urandom_range(1, len1 - 1)) : -1;
    if (cfg_at == -3)  cfg_at  = int'($urandom_range(0, len1 - 2));
    d2 = (cfg_at >= 0) ? div_of(new_cfg) : d1;

    br_cfg   = cfg;
    tx_data  = b1;
    tx_start = 1'b1;
    @(negedge clk);
    chk("accept_tbr",  tbr,  1'b0);
    chk("accept_txd",  txd,  1'b1);
    chk("accept_busy", busy, 1'b0);
    if (hold2) tx_data = 8'hAA;
    else       tx_start = 1'b0;

    q_txd.delete(); q_busy.delete(); q_tbr.delete();
    push_frame(b1, d1, 1'b1, pair ? 1'b0 : 1'b1);
    if (pair) push_frame(b2, d2, 1'b1, 1'b1);
    push_idle(3);

    i = 0;
    while (q_txd.size() > 0) begin
      step_check(i);
      tx_start = 1'b0;
      if (pair && i == 0) begin
        tx_start = 1'b1;
        tx_data  = b2;
      end
      if (i == junk_at) begin
        tx_start = 1'b1;
        tx_data  = 8'hAA;
      end
      if (i == cfg_at) br_cfg = new_cfg;
      i++;
    end
    tx_start = 1'b0;
  endtask

  task automatic reset_test(input logic [1:0] cfg);
    int d, target;
    d = div_of(cfg);
    target = 5 * d + d / 2;
    br_cfg   = cfg;
    tx_data  = 8'h4F;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    q_txd.delete(); q_busy.delete(); q_tbr.delete();
    push_frame(8'h4F, d, 1'b1, 1'b1);
    for (int i = 0; i <= target; i++) step_check(i);
    rst = 1'b0;
    #1;
    chk("rst_async_txd",  txd,  1'b1);
    chk("rst_async_tbr",  tbr,  1'b1);
    chk("rst_async_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q_txd.delete(); q_busy.delete(); q_tbr.delete();
    push_idle(NB * d + 4);
    for (int i = 0; q_txd.size() > 0; i++) step_check(i);
  endtask

  initial begin
    logic [1:0] r_cfg, r_new;
    logic [7:0] r_b1, r_b2;
    logic       r_pair, r_hold2;

    rst      = 1'b0;
    br_cfg   = 2'b00;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txd",  txd,  1'b1);
    chk("reset_tbr",  tbr,  1'b1);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    do_test(2'b00, 8'h48, 1'b0, 8'h00, 1'b0, -1, -1, 2'b00);
    do_test(2'b11, 8'h45, 1'b1, 8'h4C, 1'b0, -2, -1, 2'b11);
    do_test(2'b11, 8'h45, 1'b1, 8'h4C, 1'b0, 17, -1, 2'b11);
    do_test(2'b10, 8'h3C, 1'b0, 8'h00, 1'b1, -1, -1, 2'b10);
    do_test(2'b00, 8'h5A, 1'b1, 8'h33, 1'b0, -1, 100, 2'b01);
    do_test(2'b10, 8'h49, 1'b0, 8'h00, 1'b0, -1, -1, 2'b10);
    reset_test(2'b01);

    for (int it = 0; it < 10; it++) begin
      r_cfg   = 2'($urandom_range(0, 3));
      r_new   = 2'($urandom_range(0, 3));
      r_b1    = 8'($urandom);
      r_b2    = 8'($urandom);
      r_pair  = 1'($urandom_range(0, 1));
      r_hold2 = 1'($urandom_range(0, 1));
      do_test(r_cfg, r_b1, r_pair, r_b2, r_hold2, -3, r_pair ? -3 : -1, r_new);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
